// File: rtl/mips_mem_responder.sv
//============================================================================
// Module   : mips_mem_responder
// Brief    : Boot-loaded word memory serving a MIPS CPU; holds the CPU in
//            reset while a loader streams the program image in.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mips_mem_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             reload,
    output logic             cpu_rst,
    output logic             load_done,
    output logic             load_wrap,
    output logic [WIDTH:0]   load_count
);

    localparam int               c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] c_ptr_last  = WIDTH'(DEPTH - 1);
    localparam logic [WIDTH:0]   c_count_max = (WIDTH+1)'(DEPTH);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH:0]   r_load_count;
    logic             r_load_wrap;
    logic [WIDTH-1:0] r_memdata;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [c_aw-1:0]  w_cpu_idx;
    logic [c_aw-1:0]  w_load_idx;
    logic [c_aw-1:0]  w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_load_accept;
    logic             w_cpu_write;
    logic             w_cpu_read;
    logic             w_enter_load;
    logic             w_mem_we;

    // A full-range memory maps the address straight through; a short one wraps it.
    generate
        if (DEPTH == 2**WIDTH) begin : g_full_map
            assign w_cpu_idx = c_aw'(adr);
        end else begin : g_mod_map
            assign w_cpu_idx = c_aw'(adr % WIDTH'(DEPTH));
        end
    endgenerate

    assign w_load_idx = c_aw'(r_ptr);

    always_comb begin
        w_state_next  = r_state;
        cpu_rst       = 1'b1;
        load_done     = 1'b0;
        w_load_accept = 1'b0;
        w_cpu_write   = 1'b0;
        w_cpu_read    = 1'b0;
        w_enter_load  = 1'b0;
        case (r_state)
            LOAD: begin
                w_load_accept = load_valid;
                if (load_valid && load_last) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                cpu_rst     = 1'b0;
                load_done   = 1'b1;
                w_cpu_write = memwrite;
                w_cpu_read  = memread;
                if (reload) begin
                    w_state_next = LOAD;
                    w_enter_load = 1'b1;
                end
            end
            default: w_state_next = LOAD;
        endcase
    end

    // Reset outranks everything, so a write arriving with rst is dropped too.
    assign w_mem_we  = !rst && (w_load_accept || w_cpu_write);
    assign w_wr_idx  = w_cpu_write ? w_cpu_idx : w_load_idx;
    assign w_wr_data = w_cpu_write ? writedata : load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOAD;
            r_ptr        <= '0;
            r_load_count <= '0;
            r_load_wrap  <= 1'b0;
            r_memdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_load) begin
                r_ptr        <= '0;
                r_load_count <= '0;
                r_load_wrap  <= 1'b0;
            end else if (w_load_accept) begin
                if (r_ptr == c_ptr_last) begin
                    r_ptr       <= '0;
                    r_load_wrap <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + WIDTH'(1);
                end
                if (r_load_count != c_count_max) begin
                    r_load_count <= r_load_count + (WIDTH+1)'(1);
                end
            end
            // Simultaneous read and write returns the new data.
            if (w_cpu_read) begin
                r_memdata <= w_cpu_write ? writedata : r_mem[w_cpu_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    assign memdata    = r_memdata;
    assign load_wrap  = r_load_wrap;
    assign load_count = r_load_count;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
//============================================================================
// Module   : tb_mips_mem_responder
// Brief    : Directed and random stimulus against a behavioural memory model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mips_mem_responder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst, memread, memwrite, load_valid, load_last, reload;
    logic [WIDTH-1:0] adr, writedata, load_data, memdata;
    logic             cpu_rst, load_done, load_wrap;
    logic [WIDTH:0]   load_count;

    always #5 clk = ~clk;

    mips_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .memread    (memread),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .memdata    (memdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .reload     (reload),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_wrap  (load_wrap),
        .load_count (load_count)
    );

    // Reference model state
    bit         m_run;
    int         m_ptr, m_cnt;
    bit         m_wrap;
    logic [7:0] m_md;
    bit         m_md_known;
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_ptr = 0; m_cnt = 0; m_wrap = 0;
            m_md = 8'h00; m_md_known = 1;
        end else if (!m_run) begin
            if (load_valid) begin
                m_mem[m_ptr]   = load_data;
                m_known[m_ptr] = 1;
                if (m_cnt < DEPTH) m_cnt++;
                m_ptr++;
                if (m_ptr == DEPTH) begin
                    m_ptr  = 0;
                    m_wrap = 1;
                end
                if (load_last) m_run = 1;
            end
        end else begin
            if (memread) begin
                m_md       = memwrite ? writedata : m_mem[adr];
                m_md_known = memwrite ? 1'b1 : m_known[adr];
            end
            if (memwrite) begin
                m_mem[adr]   = writedata;
                m_known[adr] = 1;
            end
            if (reload) begin
                m_run = 0; m_ptr = 0; m_cnt = 0; m_wrap = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cpu_rst", 32'(cpu_rst), 32'(!m_run));
        chk("load_done", 32'(load_done), 32'(m_run));
        chk("load_wrap", 32'(load_wrap), 32'(m_wrap));
        chk("load_count", 32'(load_count), m_cnt);
        if (m_md_known) chk("memdata", 32'(memdata), 32'(m_md));
    endtask

    task automatic cyc(input logic r, rd, wr, input logic [7:0] a, wd,
                       input logic lv, input logic [7:0] ld, input logic ll, rl);
        rst = r; memread = rd; memwrite = wr; adr = a; writedata = wd;
        load_valid = lv; load_data = ld; load_last = ll; reload = rl;
        tick();
    endtask

    initial begin
        logic [7:0] boot [4];
        logic [7:0] last_byte;
        logic [7:0] b;
        boot[0] = 8'h20; boot[1] = 8'h01; boot[2] = 8'hA5; boot[3] = 8'hFF;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 8'h05, 8'h99, 1, 8'h44, 1, 1);
        chk("rst_memdata", 32'(memdata), 32'h0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("rst_load_done", 32'(load_done), 32'h0);
        chk("rst_load_count", 32'(load_count), 32'h0);

        // Boot load of four bytes
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 1, boot[k], (k == 3), 0);
            if (k < 3) chk("cpu_rst_during_load", 32'(cpu_rst), 32'h1);
        end
        chk("boot_count", 32'(load_count), 32'd4);
        chk("boot_done", 32'(load_done), 32'h1);
        chk("boot_cpu_rst_low", 32'(cpu_rst), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 8'(k), 0, 0, 0, 0, 0);
            chk("boot_read", 32'(memdata), 32'(boot[k]));
        end

        // Write then read, and write-first on combined access
        cyc(0, 0, 1, 8'h10, 8'h3C, 0, 0, 0, 0);
        cyc(0, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("rd_0x10", 32'(memdata), 32'h3C);
        cyc(0, 1, 1, 8'h22, 8'h77, 0, 0, 0, 0);
        chk("rw_0x22", 32'(memdata), 32'h77);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_memdata", 32'(memdata), 32'h77);
        cyc(0, 1, 0, 8'h22, 0, 0, 0, 0, 0);
        chk("rd_0x22", 32'(memdata), 32'h77);

        // CPU accesses ignored during LOAD
        cyc(0, 0, 1, 8'h05, 8'h5A, 0, 0, 0, 0);
        cyc(0, 1, 0, 8'h05, 0, 0, 0, 0, 1);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("reload_count", 32'(load_count), 32'h0);
        cyc(0, 1, 1, 8'h05, 8'h99, 0, 0, 0, 1);
        chk("load_memdata_hold", 32'(memdata), 32'h5A);
        cyc(0, 0, 0, 0, 0, 0, 8'h11, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1, 8'(8'h60 + k), (k == 2), 0);
        cyc(0, 1, 0, 8'h05, 0, 0, 0, 0, 0);
        chk("mem5_unchanged", 32'(memdata), 32'h5A);

        // 257-byte load wraps the pointer and saturates the count
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        last_byte = 8'h00;
        for (int k = 0; k < 257; k++) begin
            b = 8'($urandom);
            if (k == 256) last_byte = b;
            cyc(0, 0, 0, 0, 0, 1, b, (k == 256), 0);
        end
        chk("wrap_flag", 32'(load_wrap), 32'h1);
        chk("wrap_count", 32'(load_count), 32'd256);
        cyc(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        chk("wrap_mem0", 32'(memdata), 32'(last_byte));

        // Random traffic in both states, with occasional reset and reload
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
        end

        // Reset abandons a load part way through
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 8'h01, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 8'hB1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 8'hB2, 0, 0);
        cyc(1, 1, 1, 8'h00, 8'hEE, 1, 8'hB3, 1, 1);
        chk("abort_count", 32'(load_count), 32'h0);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("abort_done", 32'(load_done), 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 8'hC3, 1, 0);
        chk("abort_ptr_restart", 32'(load_count), 32'd1);
        cyc(0, 1, 0, 8'h01, 0, 0, 0, 0, 0);
        chk("abort_byte_kept", 32'(memdata), 32'hB2);
        cyc(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        chk("abort_mem0", 32'(memdata), 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 Parameter WIDTH, default 8, data and address width in bits.
REQ-002 Parameter DEPTH, default 2**WIDTH, number of WIDTH-bit memory words.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 memread  input  1  CPU read request.
REQ-006 memwrite  input  1  CPU write request.
REQ-007 adr  input  WIDTH  CPU word address.
REQ-008 writedata  input  WIDTH  CPU write data.
REQ-009 memdata  output  WIDTH  registered read data returned to the CPU.
REQ-010 load_valid  input  1  boot-loader byte valid.
REQ-011 load_data  input  WIDTH  boot-loader byte.
REQ-012 load_last  input  1  qualifies the final loader byte; sampled only with load_valid.
REQ-013 reload  input  1  request a return to LOAD from RUN.
REQ-014 cpu_rst  output  1  reset drive to the CPU; high whenever the state is not RUN.
REQ-015 load_done  output  1  high in RUN.
REQ-016 load_wrap  output  1  sticky flag: the load pointer wrapped during a load.
REQ-017 load_count  output  WIDTH+1  bytes written in the current/last load, saturating at DEPTH.

Function
REQ-018 The FSM SHALL have two states, LOAD and RUN, plus an internal WIDTH-bit load pointer.
REQ-019 In LOAD, each edge with load_valid=1 SHALL write load_data to mem[ptr], then increment ptr modulo DEPTH.
REQ-020 A pointer increment from DEPTH-1 to 0 SHALL set load_wrap, which stays set until rst or a new LOAD entry.
REQ-021 In LOAD, load_count SHALL increment on each accepted byte, saturating at DEPTH.
REQ-022 load_valid=1 with load_last=1 in LOAD SHALL write the byte and move to RUN on that edge; cpu_rst drops low in the first cycle after that edge.
REQ-023 load_last with load_valid=0 SHALL be ignored.
REQ-024 In LOAD, memread and memwrite SHALL be ignored: no memory write, and memdata holds its value.
REQ-025 In RUN, memwrite=1 SHALL write writedata to mem[adr] on the edge.
REQ-026 In RUN, memread=1 with memwrite=0 SHALL load memdata with mem[adr] on the edge (latency of one cycle).
REQ-027 In RUN, memread=1 and memwrite=1 together SHALL write mem[adr], and memdata SHALL take writedata (write-first).
REQ-028 In RUN with memread=0, memdata SHALL hold its last value.
REQ-029 In RUN, load_valid SHALL be ignored.
REQ-030 reload=1 in RUN SHALL, on the edge, move to LOAD, clear ptr, load_count and load_wrap, and raise cpu_rst the next cycle.
REQ-031 A CPU access in the same cycle as reload SHALL still complete under RUN rules.
REQ-032 reload in LOAD SHALL be ignored.
REQ-033 Addresses SHALL cover the whole DEPTH; there is no out-of-range case when DEPTH=2**WIDTH.
REQ-034 If DEPTH<2**WIDTH, CPU accesses SHALL use adr modulo DEPTH.

Reset
REQ-035 rst=1 SHALL force, on the edge, state=LOAD, ptr=0, memdata=0, load_count=0, load_wrap=0 and cpu_rst=1; load_done is 0 as a consequence of LOAD.
REQ-036 rst SHALL take priority over every other input, including load_last and reload, in the same cycle.
REQ-037 Memory contents SHALL NOT be cleared by rst.
REQ-038 rst asserted mid-load SHALL abandon the load; bytes already written SHALL remain in memory.

Verification
REQ-039 Reset, then load 4 bytes 0x20,0x01,0xA5,0xFF with last on the fourth -> load_count=4 and load_done=1; cpu_rst drops one cycle after the last byte; reads of adr 0..3 return those bytes one cycle after each memread.
REQ-040 In RUN, memwrite adr=0x10 data=0x3C, then memread adr=0x10 -> memdata=0x3C on the cycle after the read edge.
REQ-041 In RUN, memread=memwrite=1 at adr=0x22 with data=0x77 -> memdata=0x77 next cycle, and a later read of 0x22 returns 0x77.
REQ-042 Load 257 bytes, last on the 257th -> load_wrap=1, load_count=256, mem[0] holds byte 257.
REQ-043 In LOAD, drive memwrite adr=0x05 data=0x99 -> mem[5] unchanged and memdata unchanged.
REQ-044 In RUN, pulse reload, then rst mid-load after 2 bytes -> state LOAD, ptr=0, load_count=0, cpu_rst=1; the 2 bytes remain in memory.
